vga_fade_out: RTL and testbench
===============================

Name: vga_fade_out

Overview:
- Output stage sitting directly downstream of the raster renderer, in place of the top level's inline VGA register block.
- Takes 12-bit RGB444 colour plus display timing (de, hsync, vsync, frame) and scales colour by a global brightness level.
- Brightness ramps up or down one level every FRAMES_PER_STEP frames under a start/direction command.
- Blanks colour outside de, delays sync to match colour latency, and drives the VGA Pmod pins.

Parameters:
- FRAMES_PER_STEP, 4: frames between brightness level changes during a ramp; legal range 1..255.
- INIT_LEVEL, 16: brightness level after reset; legal range 0..16.

Ports:
- clk_pix  in  1  pixel clock
- rst_pix  in  1  reset, asynchronous, active-high
- frame  in  1  one-cycle pulse at start of frame, from display timing
- de  in  1  data enable, aligned with colr_in
- hsync  in  1  horizontal sync, aligned with colr_in
- vsync  in  1  vertical sync, aligned with colr_in
- colr_in  in  12  RGB444 colour, {r,g,b}
- sx0  in  1  LSB of screen x; used only with dithering
- sy0  in  1  LSB of screen y; used only with dithering
- fade_start  in  1  one-cycle command pulse to begin a ramp
- fade_dir  in  1  sampled with fade_start; 1 = ramp up to 16, 0 = ramp down to 0
- vga_hsync  out  1  registered, delayed hsync
- vga_vsync  out  1  registered, delayed vsync
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- level  out  5  current brightness level, 0..16
- fade_busy  out  1  high while a ramp is in progress
- fade_done  out  1  one-cycle pulse when a ramp reaches its target

Behaviour:
- Reset values:
  - vga_r, vga_g, vga_b = 0
  - vga_hsync, vga_vsync = 1
  - level = INIT_LEVEL
  - fade_busy = 0, fade_done = 0
  - state IDLE, frame counter 0
  - all internal pipeline registers: colour 0, syncs 1, de 0
- Datapath, fixed 2-cycle latency from colr_in/de/hsync/vsync to outputs:
  - Stage 1 registers per channel: p = c * level (4b x 5b -> 8b product), plus de and the syncs.
  - Stage 2 registers: out = p[7:4] when de is 1, else 0. The syncs are passed through.
  - level = 16 yields out = c exactly; level = 0 yields black.
- A level change takes effect on the next cycle's stage-1 multiply. Mid-line changes are permitted; no frame alignment of level is required.
- State machine IDLE/RAMP; target register tgt is 0 or 16:
  - IDLE, fade_start:
    - If level == target, stay in IDLE and pulse fade_done the next cycle.
    - Otherwise, latch tgt, clear the counter, and go to RAMP.
  - RAMP, frame pulse:
    - If counter == FRAMES_PER_STEP-1, clear the counter and step level by +1 or -1 toward tgt.
    - Otherwise, increment the counter.
  - RAMP, level step that reaches tgt: go to IDLE and pulse fade_done in that same registered update.
  - RAMP, fade_start: restart. Latch the new tgt, clear the counter, keep the current level. A restart toward the value already reached behaves as the IDLE case.
- fade_start and frame in the same cycle: fade_start wins and that frame is not counted.
- fade_busy = (state == RAMP), registered.
- level never leaves 0..16; no wrap-around.
- Asynchronous reset mid-ramp aborts immediately to the reset values.

Optional Feature:
- Macro: VGA_FADE_DITHER_EN.
- Defined:
  - 2x2 ordered dither in stage 2: out = (p + T)[7:4].
  - T is 0, 8, 12, 4 for {sy0,sx0} = 00, 01, 10, 11.
  - sx0/sy0 must be aligned with colr_in and are delayed one cycle internally.
  - No saturation is needed: max p + T = 225 + 12, and level 16 gives exact c.
- Undefined: truncation only; sx0/sy0 are ignored (lint-waived unused).

Decomposition:
- Package vga_fade_pkg:
  - typedef fade_state_t {IDLE, RAMP}
  - LEVEL_W = 5, LEVEL_MAX = 16
  - RGB channel width CHANW = 4
  - Bayer 2x2 threshold constants
- One sub-module: vga_fade_chan, a single-channel multiply/dither/blank pipeline instantiated three times. The state machine stays in vga_fade_out.

Test Plan:
- Reset, then colr_in = 12'hF84, de = 1, INIT_LEVEL = 16 -> after 2 cycles vga_r/g/b = F/8/4; with de = 0 -> 0/0/0; syncs delayed exactly 2 cycles.
- fade_start with fade_dir = 0, FRAMES_PER_STEP = 4, 64 frame pulses -> level decrements every 4th frame, reaches 0 after frame 64; fade_done pulses once; fade_busy falls the same cycle; output black.
- level = 8, colr_in = 12'hFFF, de = 1 -> outputs 7/7/7 (15 * 8 = 120 -> 7).
- Mid-ramp fade_start with fade_dir = 1 at level 10, coincident with a frame pulse -> frame not counted, counter 0, level rises to 16 after 24 more frames.
- fade_start toward the current level (level = 16, fade_dir = 1) -> no RAMP, fade_done one pulse, fade_busy stays 0.
- VGA_FADE_DITHER_EN: level = 8, c = 1 (p = 8), {sy0,sx0} sweep 00/01/10/11 -> outputs 0/1/1/0; reset asserted mid-ramp -> level = INIT_LEVEL asynchronously.

Source files
------------

// File: rtl/vga_fade_pkg.sv
// Shared types and constants for the VGA fade output stage.
// Provides the fade FSM state type, level and channel widths, and the 2x2 ordered-dither
// thresholds used when VGA_FADE_DITHER_EN is defined.
package vga_fade_pkg;

  localparam int unsigned LEVEL_W   = 5;   // brightness level 0..16
  localparam int unsigned LEVEL_MAX = 16;  // level at which colour passes unchanged
  localparam int unsigned CHANW     = 4;   // bits per RGB channel
  localparam int unsigned PRODW     = 8;   // channel x level product width
  localparam int unsigned THRW      = 4;   // dither threshold width

  typedef enum logic {
    IDLE,
    RAMP
  } fade_state_t;

  // Bayer 2x2 thresholds, indexed by {sy0, sx0}
  localparam logic [THRW-1:0] BAYER_00 = 4'd0;
  localparam logic [THRW-1:0] BAYER_01 = 4'd8;
  localparam logic [THRW-1:0] BAYER_10 = 4'd12;
  localparam logic [THRW-1:0] BAYER_11 = 4'd4;

  function automatic logic [THRW-1:0] bayer_thr(input logic sy, input logic sx);
    logic [THRW-1:0] thr;
    case ({sy, sx})
      2'b00:   thr = BAYER_00;
      2'b01:   thr = BAYER_01;
      2'b10:   thr = BAYER_10;
      default: thr = BAYER_11;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/vga_fade_chan.sv
// Single colour channel pipeline: multiply by brightness level, optionally add a dither
// threshold, take the top nibble, and blank outside display enable.
// Ports:
//   clk_i, rst_i   pixel clock, asynchronous active-high reset
//   colr_i         channel value aligned with the raw display timing
//   level_i        current brightness level, sampled by the stage-1 multiply
//   de_s1_i        display enable delayed by one cycle (aligned with the product)
//   thr_i          dither threshold aligned with the product (zero when dither is off)
//   colr_o         registered channel output, two cycles after colr_i
module vga_fade_chan
  import vga_fade_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [CHANW-1:0]   colr_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               de_s1_i,
  input  logic [THRW-1:0]    thr_i,
  output logic [CHANW-1:0]   colr_o
);

  logic [PRODW-1:0] prod_d, prod_q, sum;
  logic [CHANW-1:0] out_d, out_q;

  always_comb begin
    // 15 * 16 = 240 fits in 8 bits; adding a threshold of at most 12 to 225 still fits
    prod_d = PRODW'(colr_i) * PRODW'(level_i);
    sum    = prod_q + PRODW'(thr_i);
    out_d  = de_s1_i ? sum[PRODW-1:PRODW-CHANW] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q <= '0;
      out_q  <= '0;
    end else begin
      prod_q <= prod_d;
      out_q  <= out_d;
    end
  end

  assign colr_o = out_q;

endmodule

// File: rtl/vga_fade_out.sv
// VGA output stage with global brightness fade.
// Scales RGB444 colour by a brightness level (0..16) over a fixed two-cycle pipeline, blanks
// colour outside de, delays the syncs to match, and ramps the level one step every
// FRAMES_PER_STEP frames on a fade_start command.
// Optional feature: define VGA_FADE_DITHER_EN for a 2x2 ordered dither using sx0/sy0.
// Ports:
//   clk_pix, rst_pix             pixel clock, asynchronous active-high reset
//   frame, de, hsync, vsync      display timing, aligned with colr_in
//   colr_in                      {r,g,b} colour; sx0/sy0 screen LSBs (dither only)
//   fade_start, fade_dir         ramp command; dir 1 = up to 16, 0 = down to 0
//   vga_hsync, vga_vsync         delayed syncs; vga_r/g/b scaled colour
//   level, fade_busy, fade_done  ramp status
module vga_fade_out
  import vga_fade_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned INIT_LEVEL      = 16
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic               frame,
  input  logic               de,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [11:0]        colr_in,
  input  logic               sx0,
  input  logic               sy0,
  input  logic               fade_start,
  input  logic               fade_dir,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic [LEVEL_W-1:0] level,
  output logic               fade_busy,
  output logic               fade_done
);

  localparam logic [7:0] CntLast = 8'(FRAMES_PER_STEP - 1);

  fade_state_t        state_q;
  logic [7:0]         cnt_q;
  logic [LEVEL_W-1:0] level_q, tgt_q, start_tgt, step_level;
  logic               busy_q, done_q;
  logic               de_s1_q, hs_s1_q, vs_s1_q, hs_s2_q, vs_s2_q;
  logic [THRW-1:0]    thr_s1;

  // ---------------------------------------------------------------------------
  // Timing pipeline: syncs follow colour through both stages, de through stage 1
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      de_s1_q <= 1'b0;
      hs_s1_q <= 1'b1;
      vs_s1_q <= 1'b1;
      hs_s2_q <= 1'b1;
      vs_s2_q <= 1'b1;
    end else begin
      de_s1_q <= de;
      hs_s1_q <= hsync;
      vs_s1_q <= vsync;
      hs_s2_q <= hs_s1_q;
      vs_s2_q <= vs_s1_q;
    end
  end

`ifdef VGA_FADE_DITHER_EN
  logic sx_s1_q, sy_s1_q;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx_s1_q <= 1'b0;
      sy_s1_q <= 1'b0;
    end else begin
      sx_s1_q <= sx0;
      sy_s1_q <= sy0;
    end
  end

  assign thr_s1 = bayer_thr(sy_s1_q, sx_s1_q);
`else
  logic unused_dither;
  assign unused_dither = sx0 ^ sy0;
  assign thr_s1        = '0;
`endif

  vga_fade_chan u_chan_r (
    .clk_i   (clk_pix),
    .rst_i   (rst_pix),
    .colr_i  (colr_in[11:8]),
    .level_i (level_q),
    .de_s1_i (de_s1_q),
    .thr_i   (thr_s1),
    .colr_o  (vga_r)
  );

  vga_fade_chan u_chan_g (
    .clk_i   (clk_pix),
    .rst_i   (rst_pix),
    .colr_i  (colr_in[7:4]),
    .level_i (level_q),
    .de_s1_i (de_s1_q),
    .thr_i   (thr_s1),
    .colr_o  (vga_g)
  );

  vga_fade_chan u_chan_b (
    .clk_i   (clk_pix),
    .rst_i   (rst_pix),
    .colr_i  (colr_in[3:0]),
    .level_i (level_q),
    .de_s1_i (de_s1_q),
    .thr_i   (thr_s1),
    .colr_o  (vga_b)
  );

  // ---------------------------------------------------------------------------
  // Fade state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    start_tgt  = fade_dir ? LEVEL_W'(LEVEL_MAX) : '0;
    // In RAMP level never equals tgt, so the step cannot leave 0..16
    step_level = (tgt_q == LEVEL_W'(LEVEL_MAX)) ? level_q + 1'b1 : level_q - 1'b1;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= LEVEL_W'(INIT_LEVEL);
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // fade_start takes priority over frame; a coincident frame is not counted
      if (fade_start) begin
        cnt_q <= '0;
        if (level_q == start_tgt) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          tgt_q   <= start_tgt;
          state_q <= RAMP;
          busy_q  <= 1'b1;
        end
      end else if (state_q == RAMP && frame) begin
        if (cnt_q == CntLast) begin
          cnt_q   <= '0;
          level_q <= step_level;
          if (step_level == tgt_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign vga_hsync = hs_s2_q;
  assign vga_vsync = vs_s2_q;
  assign level     = level_q;
  assign fade_busy = busy_q;
  assign fade_done = done_q;

endmodule

// File: tb/tb_vga_fade_out.sv
// Directed testbench for vga_fade_out with FRAMES_PER_STEP = 4 and INIT_LEVEL = 16.
module tb_vga_fade_out;

  logic        clk_pix = 1'b0;
  logic        rst_pix = 1'b1;
  logic        frame = 1'b0, de = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [11:0] colr_in = 12'h000;
  logic        sx0 = 1'b0, sy0 = 1'b0;
  logic        fade_start = 1'b0, fade_dir = 1'b0;
  logic        vga_hsync, vga_vsync;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [4:0]  level;
  logic        fade_busy, fade_done;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  vga_fade_out #(
    .FRAMES_PER_STEP (4),
    .INIT_LEVEL      (16)
  ) dut (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .frame      (frame),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .colr_in    (colr_in),
    .sx0        (sx0),
    .sy0        (sy0),
    .fade_start (fade_start),
    .fade_dir   (fade_dir),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .level      (level),
    .fade_busy  (fade_busy),
    .fade_done  (fade_done)
  );

  always #5 clk_pix = ~clk_pix;

  // Inputs are driven and outputs sampled 2 time units after each rising edge
  task automatic tick();
    @(posedge clk_pix);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic pulse_start(input logic dir);
    fade_start = 1'b1;
    fade_dir   = dir;
    tick();
    fade_start = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_sync", {vga_hsync, vga_vsync}, 2'b11);
    chk("rst_level", level, 16);
    chk("rst_flags", {fade_busy, fade_done}, 2'b00);
    rst_pix = 1'b0;
    tick();

    // Level 16 passes colour exactly; syncs and colour delayed two cycles
    colr_in = 12'hF84;
    de      = 1'b1;
    hsync   = 1'b0;
    tick();
    chk("lat1_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("lat1_hsync", vga_hsync, 1'b1);
    tick();
    chk("lat2_rgb", {vga_r, vga_g, vga_b}, 12'hF84);
    chk("lat2_hsync", vga_hsync, 1'b0);
    de    = 1'b0;
    hsync = 1'b1;
    vsync = 1'b0;
    tick();
    chk("vsync_lat1", vga_vsync, 1'b1);
    tick();
    chk("de0_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("vsync_lat2", {vga_hsync, vga_vsync}, 2'b10);
    vsync = 1'b1;

    // Ramp down from 16 to 0 over 64 frames
    pulse_start(1'b0);
    chk("down_busy", {fade_busy, level}, {1'b1, 5'd16});
    for (int f = 1; f <= 64; f++) begin
      pulse_frame();
      if (f == 3) chk("down_f3", level, 16);
      if (f == 4) chk("down_f4", level, 15);
      if (f == 32) begin
        chk("down_f32", level, 8);
        colr_in = 12'hFFF;
        de      = 1'b1;
        tick();
        tick();
        chk("lvl8_rgb", {vga_r, vga_g, vga_b}, 12'h777);
      end
      if (f == 63) chk("down_f63", {fade_busy, fade_done, level}, {2'b10, 5'd1});
      if (f == 64) chk("down_f64", {fade_busy, fade_done, level}, {2'b01, 5'd0});
      tick();
      if (f == 64) chk("down_done_once", fade_done, 1'b0);
    end
    chk("black_rgb", {vga_r, vga_g, vga_b}, 12'h000);

    // Ramp up, then restart at level 10 with a coincident frame pulse
    pulse_start(1'b1);
    for (int f = 1; f <= 42; f++) begin
      pulse_frame();
      tick();
    end
    chk("up_f42", level, 10);
    fade_start = 1'b1;
    fade_dir   = 1'b1;
    frame      = 1'b1;
    tick();
    fade_start = 1'b0;
    frame      = 1'b0;
    chk("restart", {fade_busy, level}, {1'b1, 5'd10});
    tick();
    for (int f = 1; f <= 24; f++) begin
      pulse_frame();
      if (f == 23) chk("restart_f23", {fade_busy, level}, {1'b1, 5'd15});
      if (f == 24) chk("restart_f24", {fade_busy, fade_done, level}, {2'b01, 5'd16});
      tick();
    end

    // Command toward the level already held
    pulse_start(1'b1);
    chk("noop_start", {fade_busy, fade_done, level}, {2'b01, 5'd16});
    tick();
    chk("noop_after", {fade_busy, fade_done}, 2'b00);

    // Ramp down to 8 and leave the ramp in progress
    pulse_start(1'b0);
    for (int f = 1; f <= 32; f++) begin
      pulse_frame();
      tick();
    end
    chk("mid_lvl8", {fade_busy, level}, {1'b1, 5'd8});

`ifdef VGA_FADE_DITHER_EN
    // p = 8: thresholds 0/8/12/4 give 0/1/1/0
    colr_in = 12'h111;
    de      = 1'b1;
    {sy0, sx0} = 2'b00;
    tick();
    tick();
    chk("dith_00", {vga_r, vga_g, vga_b}, 12'h000);
    {sy0, sx0} = 2'b01;
    tick();
    tick();
    chk("dith_01", {vga_r, vga_g, vga_b}, 12'h111);
    {sy0, sx0} = 2'b10;
    tick();
    tick();
    chk("dith_10", {vga_r, vga_g, vga_b}, 12'h111);
    {sy0, sx0} = 2'b11;
    tick();
    tick();
    chk("dith_11", {vga_r, vga_g, vga_b}, 12'h000);
`endif

    // Asynchronous reset mid-ramp
    #1;
    rst_pix = 1'b1;
    #1;
    chk("arst_level", level, 16);
    chk("arst_flags", {fade_busy, fade_done}, 2'b00);
    chk("arst_rgb", {vga_r, vga_g, vga_b}, 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
